ysyx_25020047_mem_arbiter: RTL and testbench



---
 rtl/ysyx_25020047_mem_arbiter_pkg.sv | 21 ++
 rtl/ysyx_25020047_mem_arbiter_if.sv | 26 ++
 rtl/ysyx_25020047_arb_timer.sv | 34 +++
 rtl/ysyx_25020047_mem_arbiter.sv | 137 +++++++++++++
 tb/tb_ysyx_25020047_mem_arbiter.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_25020047_mem_arbiter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------
// ysyx_25020047_pkg : shared encodings for the IFU/LSU memory arbiter
// Rev 1.0
// ----------------------------------------------------------------------
package ysyx_25020047_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_IFU = 2'd1,
    ST_WAIT_LSU = 2'd2
  } state_e;

  localparam logic [1:0] OWN_NONE  = 2'b00;
  localparam logic [1:0] OWN_IFU   = 2'b01;
  localparam logic [1:0] OWN_LSU   = 2'b10;

  localparam logic [3:0] IFU_WMASK = 4'hF;

endpackage
`default_nettype wire

// File: rtl/ysyx_25020047_mem_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------
// ysyx_25020047_mem_arbiter_if : request/response bus used on all three sides
// Rev 1.0
// ----------------------------------------------------------------------
interface ysyx_25020047_mem_arbiter_if;
  logic        valid;
  logic        ready;
  logic        wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output valid, wen, addr, wdata, wmask,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, wen, addr, wdata, wmask,
    output ready, rvalid, rdata
  );
endinterface
`default_nettype wire

// File: rtl/ysyx_25020047_arb_timer.sv
`default_nettype none
// ----------------------------------------------------------------------
// ysyx_25020047_arb_timer : response-wait counter, flags the last allowed cycle
// Rev 1.0
// ----------------------------------------------------------------------
module ysyx_25020047_arb_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int             W    = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0]   LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign expire_o = (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/ysyx_25020047_mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------
// ysyx_25020047_mem_arbiter : shares one memory port between IFU and LSU
// Rev 1.0
// ----------------------------------------------------------------------
module ysyx_25020047_mem_arbiter
  import ysyx_25020047_pkg::*;
#(
  parameter int TIMEOUT    = 255,
  parameter int STARVE_MAX = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  ysyx_25020047_mem_arbiter_if.slave  ifu,
  ysyx_25020047_mem_arbiter_if.slave  lsu,
  ysyx_25020047_mem_arbiter_if.master mem,
  output logic                        bus_err_o,
  output logic [1:0]                  owner_o
);

  localparam int           SW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_CAP = SW'(STARVE_MAX);

  state_e          state_q,  state_d;
  logic [1:0]      owner_q,  owner_d;
  logic            wen_q,    wen_d;
  logic [SW-1:0]   starve_q, starve_d;

  logic            pick_lsu, pick_ifu, handshake;
  logic            tmo_clr,  tmo_en,   tmo_expire;

  ysyx_25020047_arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (tmo_clr),
    .en_i     (tmo_en),
    .expire_o (tmo_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_NONE;
      wen_q    <= 1'b0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      wen_q    <= wen_d;
      starve_q <= starve_d;
    end
  end

  // A saturated starvation count hands the next grant to a waiting IFU.
  assign pick_lsu  = lsu.valid && !(ifu.valid && (starve_q == STARVE_CAP));
  assign pick_ifu  = !pick_lsu && ifu.valid;
  assign handshake = (pick_lsu || pick_ifu) && mem.ready;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    wen_d      = wen_q;
    starve_d   = starve_q;
    ifu.ready  = 1'b0;
    ifu.rvalid = 1'b0;
    ifu.rdata  = '0;
    lsu.ready  = 1'b0;
    lsu.rvalid = 1'b0;
    lsu.rdata  = '0;
    mem.valid  = 1'b0;
    mem.wen    = 1'b0;
    mem.addr   = '0;
    mem.wdata  = '0;
    mem.wmask  = '0;
    bus_err_o  = 1'b0;
    tmo_clr    = 1'b0;
    tmo_en     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Gated by rst_n so nothing handshakes while reset is held.
        if (rst_n) begin
          if (pick_lsu) begin
            mem.valid = 1'b1;
            mem.wen   = lsu.wen;
            mem.addr  = lsu.addr;
            mem.wdata = lsu.wdata;
            mem.wmask = lsu.wmask;
            lsu.ready = mem.ready;
          end else if (pick_ifu) begin
            mem.valid = 1'b1;
            mem.addr  = ifu.addr;
            mem.wmask = IFU_WMASK;
            ifu.ready = mem.ready;
          end
          if (handshake) begin
            state_d = pick_lsu ? ST_WAIT_LSU : ST_WAIT_IFU;
            owner_d = pick_lsu ? OWN_LSU : OWN_IFU;
            wen_d   = pick_lsu && lsu.wen;
            if (pick_lsu && ifu.valid) begin
              starve_d = (starve_q == STARVE_CAP) ? starve_q : starve_q + SW'(1);
            end else begin
              starve_d = '0;
            end
          end
        end
      end
      ST_WAIT_IFU, ST_WAIT_LSU: begin
        tmo_en = 1'b1;
        // A response arriving in the expiry cycle wins over the timeout.
        if (mem.rvalid || tmo_expire) begin
          if (state_q == ST_WAIT_IFU) begin
            ifu.rvalid = 1'b1;
            ifu.rdata  = mem.rvalid ? mem.rdata : '0;
          end else begin
            lsu.rvalid = 1'b1;
            lsu.rdata  = (mem.rvalid && !wen_q) ? mem.rdata : '0;
          end
          bus_err_o = !mem.rvalid;
          state_d   = ST_IDLE;
          owner_d   = OWN_NONE;
          tmo_clr   = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  assign owner_o = owner_q;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25020047_mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------
// tb_ysyx_25020047_mem_arbiter : scoreboard bench for the IFU/LSU arbiter
// Rev 1.0
// ----------------------------------------------------------------------
module tb_ysyx_25020047_mem_arbiter;
  import ysyx_25020047_pkg::*;

  localparam int TIMEOUT    = 8;
  localparam int STARVE_MAX = 4;

  typedef struct packed {
    logic        is_lsu;
    logic [31:0] data;
  } exp_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       bus_err;
  logic [1:0] owner;

  ysyx_25020047_mem_arbiter_if ifu_bus ();
  ysyx_25020047_mem_arbiter_if lsu_bus ();
  ysyx_25020047_mem_arbiter_if mem_bus ();

  ysyx_25020047_mem_arbiter #(
    .TIMEOUT    (TIMEOUT),
    .STARVE_MAX (STARVE_MAX)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ifu       (ifu_bus),
    .lsu       (lsu_bus),
    .mem       (mem_bus),
    .bus_err_o (bus_err),
    .owner_o   (owner)
  );

  always #5 clk = ~clk;

  int   n_pass    = 0;
  int   n_checks  = 0;
  int   n_grants  = 0;
  int   n_tmo     = 0;
  int   lat_cfg   = 1;
  bit   drop_cfg  = 1'b0;
  int   stale_req = 0;
  exp_t sb[$];
  logic grant_hist[$];

  // reference model state
  bit          m_busy = 1'b0;
  int          m_sc   = 0;
  int          m_wait = 0;
  logic        exp_lsu, exp_ifu, resp;
  logic [31:0] exp_a;
  exp_t        e;
  bit          hs;
  int          hs_lat;
  logic [31:0] hs_data;
  bit          pend = 1'b0;
  int          rem  = 0;
  logic [31:0] rd;
  int          stale_done = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a == 32'h8000_0000) ? 32'h0010_0093 : (a ^ 32'h1357_9BDF);
  endfunction

  // Arbitration/response model checked on the falling edge; memory driven after the rising edge.
  always begin
    @(negedge clk);
    hs = 1'b0;
    if (!rst_n) begin
      sb.delete();
      m_busy = 1'b0;
      m_sc   = 0;
      m_wait = 0;
    end else if (!m_busy) begin
      exp_lsu = lsu_bus.valid && !(ifu_bus.valid && (m_sc == STARVE_MAX));
      exp_ifu = !exp_lsu && ifu_bus.valid;
      check_val("idle_mem_valid", {31'd0, mem_bus.valid}, {31'd0, exp_lsu | exp_ifu});
      check_val("idle_ready", {30'd0, ifu_bus.ready, lsu_bus.ready},
                {30'd0, exp_ifu && mem_bus.ready, exp_lsu && mem_bus.ready});
      check_val("idle_quiet", {29'd0, ifu_bus.rvalid, lsu_bus.rvalid, bus_err}, 32'd0);
      if (exp_lsu || exp_ifu) begin
        exp_a = exp_lsu ? lsu_bus.addr : ifu_bus.addr;
        check_val("mem_addr", mem_bus.addr, exp_a);
        check_val("mem_wen", {31'd0, mem_bus.wen}, {31'd0, exp_lsu && lsu_bus.wen});
        check_val("mem_wmask", {28'd0, mem_bus.wmask}, {28'd0, exp_lsu ? lsu_bus.wmask : 4'hF});
        check_val("mem_wdata", mem_bus.wdata, exp_lsu ? lsu_bus.wdata : 32'd0);
        if (mem_bus.ready) begin
          hs      = 1'b1;
          hs_lat  = drop_cfg ? TIMEOUT + 1 : lat_cfg;
          hs_data = mem_fn(exp_a);
          sb.push_back('{exp_lsu, (exp_lsu && lsu_bus.wen) ? 32'd0 : mem_fn(exp_a)});
          if (exp_lsu && ifu_bus.valid) m_sc = (m_sc == STARVE_MAX) ? m_sc : m_sc + 1;
          else m_sc = 0;
          m_busy = 1'b1;
          m_wait = 0;
          grant_hist.push_back(exp_lsu);
          n_grants++;
        end
      end
    end else begin
      m_wait++;
      check_val("wait_no_req", {29'd0, mem_bus.valid, ifu_bus.ready, lsu_bus.ready}, 32'd0);
      if (sb.size() == 0) begin
        check_val("sb_underflow", sb.size(), 32'd1);
        m_busy = 1'b0;
      end else begin
        check_val("wait_owner", {30'd0, owner}, {30'd0, sb[0].is_lsu ? OWN_LSU : OWN_IFU});
        resp = mem_bus.rvalid || (m_wait == TIMEOUT);
        check_val("resp_port", {30'd0, ifu_bus.rvalid, lsu_bus.rvalid},
                  resp ? (sb[0].is_lsu ? 32'd1 : 32'd2) : 32'd0);
        check_val("bus_err", {31'd0, bus_err}, {31'd0, resp && !mem_bus.rvalid});
        if (resp) begin
          e = sb.pop_front();
          if (e.is_lsu) check_val("lsu_rdata", lsu_bus.rdata, mem_bus.rvalid ? e.data : 32'd0);
          else          check_val("ifu_rdata", ifu_bus.rdata, mem_bus.rvalid ? e.data : 32'd0);
          if (!mem_bus.rvalid) n_tmo++;
          m_busy = 1'b0;
        end
      end
    end

    @(posedge clk);
    #1;
    mem_bus.rvalid = 1'b0;
    mem_bus.rdata  = 32'd0;
    if (!rst_n) pend = 1'b0;
    if (hs) begin
      pend = 1'b1;
      rem  = hs_lat;
      rd   = hs_data;
    end
    if (pend) begin
      if (rem <= 1) begin
        mem_bus.rvalid = 1'b1;
        mem_bus.rdata  = rd;
        pend           = 1'b0;
      end else begin
        rem--;
      end
    end
    if (stale_done != stale_req) begin
      mem_bus.rvalid = 1'b1;
      mem_bus.rdata  = 32'hDEAD_BEEF;
      stale_done     = stale_req;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_grants(input int target, input int budget);
    int k = 0;
    while (n_grants < target && k < budget) begin
      tick(1);
      k++;
    end
    check_val("wait_grant", n_grants, target);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (m_busy && k < budget) begin
      tick(1);
      k++;
    end
    check_val("wait_idle", {31'd0, m_busy}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int g0;
    int t0;
    ifu_bus.valid = 1'b0; ifu_bus.wen = 1'b0; ifu_bus.addr = '0; ifu_bus.wdata = '0; ifu_bus.wmask = '0;
    lsu_bus.valid = 1'b0; lsu_bus.wen = 1'b0; lsu_bus.addr = '0; lsu_bus.wdata = '0; lsu_bus.wmask = '0;
    mem_bus.ready = 1'b1;

    tick(3);
    check_val("reset_outputs", {25'd0, mem_bus.valid, ifu_bus.ready, lsu_bus.ready,
              ifu_bus.rvalid, lsu_bus.rvalid, bus_err, owner}, 32'd0);
    rst_n = 1'b1;
    tick(2);

    // IFU alone, two-cycle memory
    lat_cfg = 2;
    ifu_bus.addr = 32'h8000_0000; ifu_bus.valid = 1'b1;
    wait_grants(n_grants + 1, 10);
    ifu_bus.valid = 1'b0;
    wait_idle(20);
    check_val("t1_ifu_grant", {31'd0, grant_hist[n_grants-1]}, 32'd0);

    // Simultaneous requests: LSU first, IFU right after its response
    g0 = n_grants; lat_cfg = 3;
    ifu_bus.addr = 32'h8000_0004; ifu_bus.valid = 1'b1;
    lsu_bus.addr = 32'h8000_1000; lsu_bus.wen = 1'b0; lsu_bus.wmask = 4'hF; lsu_bus.valid = 1'b1;
    wait_grants(g0 + 1, 10);
    lsu_bus.valid = 1'b0;
    wait_grants(g0 + 2, 20);
    ifu_bus.valid = 1'b0;
    wait_idle(20);
    check_val("t2_order", {30'd0, grant_hist[g0], grant_hist[g0+1]}, 32'd2);

    // Starvation guard
    g0 = n_grants; lat_cfg = 1;
    ifu_bus.addr = 32'h8000_0008; ifu_bus.valid = 1'b1;
    lsu_bus.addr = 32'h8000_1100; lsu_bus.valid = 1'b1;
    wait_grants(g0 + 5, 40);
    ifu_bus.valid = 1'b0; lsu_bus.valid = 1'b0;
    wait_idle(20);
    check_val("t3_pattern", {27'd0, grant_hist[g0], grant_hist[g0+1], grant_hist[g0+2],
              grant_hist[g0+3], grant_hist[g0+4]}, 32'b11110);
    ifu_bus.valid = 1'b1; lsu_bus.valid = 1'b1;
    wait_grants(g0 + 6, 10);
    ifu_bus.valid = 1'b0; lsu_bus.valid = 1'b0;
    wait_idle(20);
    check_val("t3_count_cleared", {31'd0, grant_hist[g0+5]}, 32'd1);

    // Store held off by mem_ready, then acked with zero data
    g0 = n_grants; lat_cfg = 3;
    mem_bus.ready = 1'b0;
    lsu_bus.addr = 32'h8000_0010; lsu_bus.wdata = 32'hA5A5_A5A5; lsu_bus.wmask = 4'b0011;
    lsu_bus.wen = 1'b1; lsu_bus.valid = 1'b1;
    tick(2);
    check_val("t4_stalled", n_grants, g0);
    mem_bus.ready = 1'b1;
    wait_grants(g0 + 1, 10);
    lsu_bus.valid = 1'b0; lsu_bus.wen = 1'b0; lsu_bus.wmask = 4'hF;
    wait_idle(20);

    // Timeout: no response, late response ignored
    t0 = n_tmo; drop_cfg = 1'b1;
    lsu_bus.addr = 32'h8000_2000; lsu_bus.valid = 1'b1;
    wait_grants(n_grants + 1, 10);
    lsu_bus.valid = 1'b0; drop_cfg = 1'b0;
    wait_idle(TIMEOUT + 4);
    tick(3);
    check_val("t5_timeouts", n_tmo, t0 + 1);

    // Response lands exactly in the expiry cycle
    t0 = n_tmo; lat_cfg = TIMEOUT;
    ifu_bus.addr = 32'h8000_000C; ifu_bus.valid = 1'b1;
    wait_grants(n_grants + 1, 10);
    ifu_bus.valid = 1'b0;
    wait_idle(TIMEOUT + 4);
    check_val("t6_no_timeout", n_tmo, t0);

    // Asynchronous reset in WAIT_IFU, stale response afterwards
    lat_cfg = 5;
    ifu_bus.addr = 32'h8000_0010; ifu_bus.valid = 1'b1;
    wait_grants(n_grants + 1, 10);
    ifu_bus.valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("t7_async_reset", {25'd0, mem_bus.valid, ifu_bus.ready, lsu_bus.ready,
              ifu_bus.rvalid, lsu_bus.rvalid, bus_err, owner}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    stale_req++;
    tick(3);
    g0 = n_grants; lat_cfg = 2;
    ifu_bus.addr = 32'h8000_0000; ifu_bus.valid = 1'b1;
    wait_grants(g0 + 1, 10);
    ifu_bus.valid = 1'b0;
    wait_idle(20);
    tick(2);
    check_val("sb_drained", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
